// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: walks a 2-input gate through minterms 00,01,10,11, waits
// SETTLE cycles per minterm, samples the gate output into a truth table and
// compares the result against a golden table latched when the sweep starts.
module truth_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] expected,
    input  logic       s,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_out,
    output logic [3:0] mismatch,
    output logic       pass
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned TT_W  = 4;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [TT_W-1:0]   exp_q;

    logic [TT_W-1:0]   table_cap_c;
    logic [IDX_W-1:0]  idx_inc_c;

    // Truth table as it will look once the current minterm's sample is written
    always_comb begin
        table_cap_c      = table_out;
        table_cap_c[idx] = s;
    end

    // Next minterm index (only used when idx has not reached the last minterm)
    always_comb begin
        idx_inc_c = idx + IDX_W'(1);
    end

    // Sweep sequencer with registered drive, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            exp_q     <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            mismatch  <= '0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // start wins over abort here; abort is meaningless in IDLE
                    if (start) begin
                        exp_q     <= expected;
                        idx       <= '0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        cnt       <= SETTLE_LOAD;
                        table_out <= '0;
                        mismatch  <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        pass  <= 1'b0;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_ONE;
                        end
                        if (cnt <= CNT_ONE) begin
                            state <= ST_SAMPLE;
                        end
                    end
                end

                ST_SAMPLE: begin
                    // abort discards this cycle's sample; earlier bits are kept
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        a     <= 1'b0;
                        b     <= 1'b0;
                        pass  <= 1'b0;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        table_out <= table_cap_c;
                        if (idx == IDX_LAST) begin
                            // results are registered alongside the done pulse
                            mismatch <= table_cap_c ^ exp_q;
                            pass     <= (table_cap_c == exp_q);
                            done     <= 1'b1;
                            a        <= 1'b0;
                            b        <= 1'b0;
                            cnt      <= '0;
                            state    <= ST_DONE;
                        end else begin
                            idx   <= idx_inc_c;
                            a     <= idx_inc_c[1];
                            b     <= idx_inc_c[0];
                            cnt   <= SETTLE_LOAD;
                            state <= ST_SETTLE;
                        end
                    end
                end

                ST_DONE: begin
                    // abort has no effect here; results hold until next start
                    idx   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Bench for truth_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) each
// driving a behavioural gate; results checked against a timing/result model.
module tb_truth_sweep_ctrl;

    localparam int unsigned S_A = 1;
    localparam int unsigned S_B = 3;

    logic clk;
    logic rst_n;

    logic       start_v    [2];
    logic       abort_v    [2];
    logic [3:0] expected_v [2];
    logic [3:0] gate_v     [2];

    logic       a_v    [2];
    logic       b_v    [2];
    logic       busy_v [2];
    logic       done_v [2];
    logic       pass_v [2];
    logic [3:0] tab_v  [2];
    logic [3:0] mm_v   [2];

    logic       s_sa, a_sa, b_sa, busy_sa, done_sa, pass_sa;
    logic [3:0] tab_sa, mm_sa;
    logic       s_sb, a_sb, b_sb, busy_sb, done_sb, pass_sb;
    logic [3:0] tab_sb, mm_sb;

    // model memory of the last completed result per instance
    logic [3:0] last_tab  [2];
    logic [3:0] last_mm   [2];
    logic       last_pass [2];

    int n_cmp;
    int n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural gates under test: s = gate truth table indexed by {a,b}
    assign s_sa = gate_v[0][{a_sa, b_sa}];
    assign s_sb = gate_v[1][{a_sb, b_sb}];

    truth_sweep_ctrl #(.SETTLE(S_A)) u_dut_sa (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .expected(expected_v[0]), .s(s_sa), .a(a_sa), .b(b_sa),
        .busy(busy_sa), .done(done_sa), .table_out(tab_sa),
        .mismatch(mm_sa), .pass(pass_sa)
    );

    truth_sweep_ctrl #(.SETTLE(S_B)) u_dut_sb (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .expected(expected_v[1]), .s(s_sb), .a(a_sb), .b(b_sb),
        .busy(busy_sb), .done(done_sb), .table_out(tab_sb),
        .mismatch(mm_sb), .pass(pass_sb)
    );

    always_comb begin
        a_v[0] = a_sa;       a_v[1] = a_sb;
        b_v[0] = b_sa;       b_v[1] = b_sb;
        busy_v[0] = busy_sa; busy_v[1] = busy_sb;
        done_v[0] = done_sa; done_v[1] = done_sb;
        pass_v[0] = pass_sa; pass_v[1] = pass_sb;
        tab_v[0] = tab_sa;   tab_v[1] = tab_sb;
        mm_v[0] = mm_sa;     mm_v[1] = mm_sb;
    end

    function automatic int settle_of(input int k);
        return (k == 0) ? int'(S_A) : int'(S_B);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 1'b0; abort_v[k] = 1'b0;
            expected_v[k] = 4'h0; gate_v[k] = 4'h0;
            last_tab[k] = 4'h0; last_mm[k] = 4'h0; last_pass[k] = 1'b0;
        end
        #3;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if ({a_v[k], b_v[k], busy_v[k], done_v[k], pass_v[k], tab_v[k], mm_v[k]} !== 13'd0) begin
                n_err++;
                $display("FAIL reset_state k=%0d got a=%b b=%b busy=%b done=%b pass=%b tab=%b mm=%b want all 0",
                         k, a_v[k], b_v[k], busy_v[k], done_v[k], pass_v[k], tab_v[k], mm_v[k]);
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full sweep on instance k; optional mid-sweep restart, start+abort in
    // IDLE, and abort during the DONE cycle.
    task automatic run_sweep(input int k, input logic [3:0] gate, input logic [3:0] golden,
                             input bit restart, input bit abort_at_start, input bit abort_in_done,
                             input string tag);
        int st = settle_of(k);
        int n_end = 4 * (st + 1);
        logic [3:0] want_mm = gate ^ golden;
        logic       want_pass = (gate == golden);
        logic [1:0] want_ab;
        @(negedge clk);
        gate_v[k] = gate;
        expected_v[k] = golden;
        start_v[k] = 1'b1;
        abort_v[k] = abort_at_start;
        @(posedge clk);
        @(negedge clk);
        start_v[k] = 1'b0;
        abort_v[k] = 1'b0;
        for (int e = 0; e <= n_end + 1; e++) begin
            if (e < n_end) begin
                want_ab = 2'(e / (st + 1));
                n_cmp++;
                if ({a_v[k], b_v[k]} !== want_ab || done_v[k] !== 1'b0 || busy_v[k] !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s drive edge=%0d got ab=%b done=%b busy=%b want ab=%b done=0 busy=1",
                             tag, e, {a_v[k], b_v[k]}, done_v[k], busy_v[k], want_ab);
                end
            end else if (e == n_end) begin
                n_cmp++;
                if (done_v[k] !== 1'b1 || busy_v[k] !== 1'b1 || {a_v[k], b_v[k]} !== 2'b00) begin
                    n_err++;
                    $display("FAIL %s done_pulse edge=%0d got done=%b busy=%b ab=%b want done=1 busy=1 ab=00",
                             tag, e, done_v[k], busy_v[k], {a_v[k], b_v[k]});
                end
                n_cmp++;
                if (tab_v[k] !== gate || mm_v[k] !== want_mm || pass_v[k] !== want_pass) begin
                    n_err++;
                    $display("FAIL %s result got tab=%b mm=%b pass=%b want tab=%b mm=%b pass=%b",
                             tag, tab_v[k], mm_v[k], pass_v[k], gate, want_mm, want_pass);
                end
            end else begin
                n_cmp++;
                if (done_v[k] !== 1'b0 || busy_v[k] !== 1'b0 || tab_v[k] !== gate ||
                    mm_v[k] !== want_mm || pass_v[k] !== want_pass) begin
                    n_err++;
                    $display("FAIL %s after_done got done=%b busy=%b tab=%b mm=%b pass=%b want done=0 busy=0 tab=%b mm=%b pass=%b",
                             tag, done_v[k], busy_v[k], tab_v[k], mm_v[k], pass_v[k], gate, want_mm, want_pass);
                end
            end
            if (e == 1) expected_v[k] = 4'($urandom);
            if (restart && e == 2) begin
                start_v[k] = 1'b1;
                expected_v[k] = ~golden;
            end else if (restart && e == 3) begin
                start_v[k] = 1'b0;
            end
            if (abort_in_done) abort_v[k] = (e == n_end);
            if (e <= n_end) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        abort_v[k] = 1'b0;
        start_v[k] = 1'b0;
        last_tab[k] = gate;
        last_mm[k] = want_mm;
        last_pass[k] = want_pass;
    endtask

    task automatic test_basic();
        run_sweep(0, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b0, "nand_pass");
        run_sweep(0, 4'b0111, 4'b0010, 1'b0, 1'b0, 1'b0, "nand_mismatch");
    endtask

    task automatic test_settle3();
        run_sweep(1, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, "and_settle3");
    endtask

    task automatic test_restart();
        run_sweep(0, 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0, "restart_ignored");
        run_sweep(1, 4'b1110, 4'b0001, 1'b1, 1'b0, 1'b0, "restart_ignored_s3");
    endtask

    task automatic test_start_abort_idle();
        run_sweep(0, 4'b1001, 4'b1001, 1'b0, 1'b1, 1'b0, "start_with_abort");
        run_sweep(1, 4'b0001, 4'b0011, 1'b0, 1'b0, 1'b1, "abort_in_done");
    endtask

    // abort during the SAMPLE cycle of minterm 2, then a clean sweep
    task automatic test_abort(input int k);
        int st = settle_of(k);
        int n_end = 4 * (st + 1);
        logic [3:0] gate = 4'($urandom) | 4'b0011;
        int seen_done = 0;
        @(negedge clk);
        gate_v[k] = gate;
        expected_v[k] = gate;
        start_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[k] = 1'b0;
        for (int e = 1; e <= 3 * (st + 1) - 1; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        abort_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_v[k] = 1'b0;
        n_cmp++;
        if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || {a_v[k], b_v[k]} !== 2'b00 ||
            tab_v[k] !== {2'b00, gate[1:0]} || pass_v[k] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_k%0d got busy=%b done=%b ab=%b tab=%b pass=%b want busy=0 done=0 ab=00 tab=%b pass=0",
                     k, busy_v[k], done_v[k], {a_v[k], b_v[k]}, tab_v[k], pass_v[k], {2'b00, gate[1:0]});
        end
        for (int i = 0; i < 2 * n_end; i++) begin
            @(negedge clk);
            if (done_v[k] === 1'b1 || busy_v[k] !== 1'b0) seen_done++;
        end
        n_cmp++;
        if (seen_done != 0) begin
            n_err++;
            $display("FAIL abort_quiet_k%0d got %0d cycles with done/busy want 0", k, seen_done);
        end
        run_sweep(k, 4'b0110, 4'b0110, 1'b0, 1'b0, 1'b0, "after_abort");
    endtask

    // async reset between edges while minterm 1 is driven
    task automatic test_reset_mid(input int k);
        int st = settle_of(k);
        int n_end = 4 * (st + 1);
        int bad = 0;
        @(negedge clk);
        gate_v[k] = 4'b1011;
        expected_v[k] = 4'b1011;
        start_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[k] = 1'b0;
        for (int e = 1; e <= st + 1; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_cmp++;
        if ({a_v[k], b_v[k]} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_mid_pre_k%0d got ab=%b want 01", k, {a_v[k], b_v[k]});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_v[k], b_v[k], busy_v[k], done_v[k], pass_v[k], tab_v[k], mm_v[k]} !== 13'd0) begin
            n_err++;
            $display("FAIL rst_mid_k%0d got a=%b b=%b busy=%b done=%b pass=%b tab=%b mm=%b want all 0",
                     k, a_v[k], b_v[k], busy_v[k], done_v[k], pass_v[k], tab_v[k], mm_v[k]);
        end
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2 * n_end; i++) begin
            @(negedge clk);
            if (done_v[k] !== 1'b0 || busy_v[k] !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rst_mid_quiet_k%0d got %0d active cycles want 0", k, bad);
        end
        last_tab[k] = 4'h0; last_mm[k] = 4'h0; last_pass[k] = 1'b0;
        run_sweep(k, 4'b1011, 4'b1010, 1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    // abort and expected changes while idle leave results untouched
    task automatic test_idle_abort(input int k);
        @(negedge clk);
        abort_v[k] = 1'b1;
        expected_v[k] = ~expected_v[k];
        repeat (3) @(negedge clk);
        abort_v[k] = 1'b0;
        n_cmp++;
        if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || tab_v[k] !== last_tab[k] ||
            mm_v[k] !== last_mm[k] || pass_v[k] !== last_pass[k]) begin
            n_err++;
            $display("FAIL idle_abort_k%0d got busy=%b done=%b tab=%b mm=%b pass=%b want busy=0 done=0 tab=%b mm=%b pass=%b",
                     k, busy_v[k], done_v[k], tab_v[k], mm_v[k], pass_v[k], last_tab[k], last_mm[k], last_pass[k]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int k = int'($urandom_range(1, 0));
            logic [3:0] gate = 4'($urandom);
            logic [3:0] golden = ($urandom_range(1, 0) == 1) ? gate : 4'($urandom);
            run_sweep(k, gate, golden, 1'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_settle3();
        test_restart();
        test_start_abort_idle();
        test_idle_abort(0);
        test_abort(0);
        test_abort(1);
        test_reset_mid(0);
        test_reset_mid(1);
        test_idle_abort(1);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
